comp2s_to_sm: RTL and testbench

COMP2S_TO_SM -- requirements
Module: comp2s_to_sm

---
 rtl/comp2s_to_sm_pkg.sv | 16 +
 rtl/HA.sv | 14 +
 rtl/serial_fsm_states.sv | 11 +
 rtl/comp2s_to_sm.sv | 142 ++++++++++++++
 tb/tb_comp2s_to_sm.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/comp2s_to_sm_pkg.sv
// Types shared by the two's-complement to sign-magnitude converter.
// Latency: n/a (package).
// Backpressure: n/a (package).
`ifndef SERIAL_FSM_STATES_SVH
`include "serial_fsm_states.sv"
`endif

package comp2s_to_sm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = `SERIAL_ST_IDLE,
    ST_SHIFT = `SERIAL_ST_SHIFT,
    ST_DONE  = `SERIAL_ST_DONE
  } state_e;

endpackage

// File: rtl/HA.sv
// Single-bit half adder: S = A ^ B, Co = A & B.
// Latency: combinational.
// Backpressure: none.
module HA (
  input  logic A,
  input  logic B,
  output logic S,
  output logic Co
);

  assign S  = A ^ B;
  assign Co = A & B;

endmodule

// File: rtl/serial_fsm_states.sv
// State encodings shared by the bit-serial arithmetic blocks (IDLE/SHIFT/DONE).
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
`ifndef SERIAL_FSM_STATES_SVH
`define SERIAL_FSM_STATES_SVH

`define SERIAL_ST_IDLE  2'd0
`define SERIAL_ST_SHIFT 2'd1
`define SERIAL_ST_DONE  2'd2

`endif

// File: rtl/comp2s_to_sm.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first, one bit per cycle.
// Latency: input handshake at edge T -> OUT_VALID after edge T+width; one operand in flight.
// Backpressure: result held in DONE until OUT_READY; IN_READY only in IDLE.
//
// Ports: CLK/RST_N clock and async active-low reset; IN/IN_VALID/IN_READY operand
// handshake; OUT_SIGN/OUT_MAG/OUT_MIN/OUT_VALID/OUT_READY registered result handshake.
module comp2s_to_sm
  import comp2s_to_sm_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [width-1:0] IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             OUT_SIGN,
  output logic [width-1:0] OUT_MAG,
  output logic             OUT_MIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int CW = $clog2(width);
  localparam logic [CW-1:0]    CNT_LAST = CW'(width - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [width-1:0] MIN_MAG  = {1'b1, {(width-1){1'b0}}};

  state_e           state_q, state_d;
  logic [width-1:0] sreg_q, sreg_d;     // operand, shifted right one bit per cycle
  logic [width-1:0] acc_q, acc_d;       // magnitude bits enter at the MSB end
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             op_sign_q, op_sign_d;
  logic             out_sign_q, out_sign_d;
  logic [width-1:0] out_mag_q, out_mag_d;
  logic             out_min_q, out_min_d;
  logic             out_valid_q, out_valid_d;

  logic             cur_bit;
  logic             ha_s, ha_co;
  logic             mag_bit;
  logic [width-1:0] mag_next;

  assign cur_bit = sreg_q[0];

  // Serial negate (~x + 1): invert the bit and ripple the +1 carry through it.
  HA u_ha (
    .A  (~cur_bit),
    .B  (carry_q),
    .S  (ha_s),
    .Co (ha_co)
  );

  assign mag_bit  = op_sign_q ? ha_s : cur_bit;
  assign mag_next = {mag_bit, acc_q[width-1:1]};

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    op_sign_d   = op_sign_q;
    out_sign_d  = out_sign_q;
    out_mag_d   = out_mag_q;
    out_min_d   = out_min_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        if (IN_VALID) begin
          sreg_d    = IN;
          op_sign_d = IN[width-1];
          cnt_d     = '0;
          carry_d   = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sreg_d  = {1'b0, sreg_q[width-1:1]};
        acc_d   = mag_next;
        carry_d = op_sign_q ? ha_co : carry_q;
        if (cnt_q == CNT_LAST) begin
          // Result is published only once complete; outputs never see partial bits.
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_sign_d  = op_sign_q;
          out_mag_d   = mag_next;
          // Only the most negative operand negates to the lone-MSB magnitude.
          out_min_d   = op_sign_q && (mag_next == MIN_MAG);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        if (OUT_READY) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      op_sign_q   <= 1'b0;
      out_sign_q  <= 1'b0;
      out_mag_q   <= '0;
      out_min_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      op_sign_q   <= op_sign_d;
      out_sign_q  <= out_sign_d;
      out_mag_q   <= out_mag_d;
      out_min_q   <= out_min_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign OUT_SIGN  = out_sign_q;
  assign OUT_MAG   = out_mag_q;
  assign OUT_MIN   = out_min_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_comp2s_to_sm.sv
// Directed bench for comp2s_to_sm at width=8.
// Latency: expects result valid 8 edges after the input handshake.
// Backpressure: exercises held results, back-to-back operands and mid-operation reset.
module tb_comp2s_to_sm;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_dat;
  logic       in_vld;
  logic       in_rdy;
  logic       out_sign;
  logic [7:0] out_mag;
  logic       out_min;
  logic       out_vld;
  logic       out_rdy;

  int total;
  int bad;

  comp2s_to_sm #(.width(8)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .IN        (in_dat),
    .IN_VALID  (in_vld),
    .IN_READY  (in_rdy),
    .OUT_SIGN  (out_sign),
    .OUT_MAG   (out_mag),
    .OUT_MIN   (out_min),
    .OUT_VALID (out_vld),
    .OUT_READY (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
    end
  endtask

  // Sends one operand (called #1 after a rising edge), waits for the result,
  // checks it, then lets the output handshake complete (out_rdy must be 1).
  task automatic run_op(input string tag, input logic [7:0] v, input logic es,
                        input logic [7:0] em, input logic emin, input bit noisy);
    int w;
    int lat;
    w = 0;
    while (!in_rdy && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, "_rdy"}, 32'(in_rdy), 1);
    in_dat = v;
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = noisy;
    in_dat = noisy ? 8'($urandom) : 8'h00;
    chk({tag, "_busy"}, 32'(in_rdy), 0);
    lat = 0;
    while (!out_vld && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (noisy) in_dat = 8'($urandom);
    end
    in_vld = 1'b0;
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_sign"}, 32'(out_sign), 32'(es));
    chk({tag, "_mag"}, 32'(out_mag), 32'(em));
    chk({tag, "_min"}, 32'(out_min), 32'(emin));
    @(posedge clk); #1;
    chk({tag, "_vld_drop"}, 32'(out_vld), 0);
    chk({tag, "_rdy_back"}, 32'(in_rdy), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int lat;
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    in_dat  = 8'h00;
    in_vld  = 1'b0;
    out_rdy = 1'b1;

    // Reset state
    #12;
    chk("rst_vld", 32'(out_vld), 0);
    chk("rst_sign", 32'(out_sign), 0);
    chk("rst_mag", 32'(out_mag), 0);
    chk("rst_min", 32'(out_min), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_rdy", 32'(in_rdy), 1);

    // Basic conversions, one per input class
    run_op("fb",  8'hFB, 1'b1, 8'h05, 1'b0, 1'b0);
    run_op("min", 8'h80, 1'b1, 8'h80, 1'b1, 1'b0);
    run_op("zero", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("p01", 8'h01, 1'b0, 8'h01, 1'b0, 1'b0);
    run_op("p40", 8'h40, 1'b0, 8'h40, 1'b0, 1'b0);

    // Input bus churns with IN_VALID high throughout SHIFT
    run_op("noisy81", 8'h81, 1'b1, 8'h7F, 1'b0, 1'b1);

    // Back-to-back: 0xFF offered continuously after 0x7F is captured
    in_dat = 8'h7F;
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_dat = 8'hFF;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      if (k == 7) chk("b2b_vld_k7", 32'(out_vld), 0);
      if (k == 8) begin
        chk("b2b_a_vld", 32'(out_vld), 1);
        chk("b2b_a_sign", 32'(out_sign), 0);
        chk("b2b_a_mag", 32'(out_mag), 'h7F);
        chk("b2b_a_rdy", 32'(in_rdy), 0);
      end
      if (k == 9) begin
        chk("b2b_gap_vld", 32'(out_vld), 0);
        chk("b2b_gap_rdy", 32'(in_rdy), 1);
      end
      if (k == 10) chk("b2b_accept", 32'(in_rdy), 0);
      if (k == 17) chk("b2b_vld_k17", 32'(out_vld), 0);
      if (k == 18) begin
        chk("b2b_b_vld", 32'(out_vld), 1);
        chk("b2b_b_sign", 32'(out_sign), 1);
        chk("b2b_b_mag", 32'(out_mag), 'h01);
        chk("b2b_b_min", 32'(out_min), 0);
      end
    end
    in_vld = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_vld", 32'(out_vld), 0);

    // Consumer stalls for 5 cycles in DONE
    out_rdy = 1'b0;
    in_dat  = 8'hC3;
    in_vld  = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = 0;
    while (!out_vld && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_lat", lat, 8);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_vld", 32'(out_vld), 1);
      chk("hold_mag", 32'(out_mag), 'h3D);
      chk("hold_sign", 32'(out_sign), 1);
      chk("hold_in_rdy", 32'(in_rdy), 0);
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_vld", 32'(out_vld), 0);
    chk("hold_release_rdy", 32'(in_rdy), 1);

    // Reset in the middle of SHIFT abandons the operand
    in_dat = 8'h9C;
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_vld), 0);
    chk("mid_rst_mag", 32'(out_mag), 0);
    chk("mid_rst_sign", 32'(out_sign), 0);
    chk("mid_rst_min", 32'(out_min), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_vld) cnt++;
    end
    chk("mid_rst_no_result", cnt, 0);
    run_op("after_rst_f0", 8'hF0, 1'b1, 8'h10, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
